// File: rtl/operand_entry_ctrl_if.sv
// Board-side bundle for the add/sub operand sequencer: switch/key inputs and
// the value/blank controls consumed by the hex display drivers.
interface operand_entry_ctrl_if;
  logic [3:0] sw_val;
  logic       sub_sel;
  logic       key_enter_n;
  logic       key_clear_n;
  logic [3:0] a_val;
  logic [3:0] b_val;
  logic [3:0] r_val;
  logic       ovf;
  logic       ovf_show;
  logic       a_blank;
  logic       b_blank;
  logic       r_blank;
  logic [1:0] state_o;

  modport master (
    output sw_val, sub_sel, key_enter_n, key_clear_n,
    input  a_val, b_val, r_val, ovf, ovf_show, a_blank, b_blank, r_blank, state_o
  );

  modport slave (
    input  sw_val, sub_sel, key_enter_n, key_clear_n,
    output a_val, b_val, r_val, ovf, ovf_show, a_blank, b_blank, r_blank, state_o
  );
endinterface

// File: rtl/operand_entry_ctrl.sv
// Operand entry sequencer for the 4-bit two's-complement add/sub lab datapath:
// debounced ENTER/CLEAR keys step A -> B -> EXEC -> SHOW and drive display blanking.
module operand_entry_ctrl #(
  parameter int DEB_CYCLES = 50000,
  parameter int BLINK_DIV  = 12500000
) (
  input logic clk,
  input logic rst_n,
  operand_entry_ctrl_if.slave io
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    EXEC    = 2'd2,
    SHOW    = 2'd3
  } state_t;

  logic [1:0] key_raw;
  logic [1:0] key_meta;
  logic [1:0] key_sync;
  logic [1:0] key_pulse;
  logic       enter_p;
  logic       clear_p;

  state_t     state;
  state_t     state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] r_q, r_d;
  logic       ovf_q, ovf_d;
  logic       sub_q, sub_d;

  logic signed [5:0] a_ext;
  logic signed [5:0] b_ext;
  logic signed [5:0] sum6;
  logic              sum_ovf;

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  assign key_raw = {io.key_clear_n, io.key_enter_n};

  // Keys are asynchronous pins; both pass through a two-flop synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= 2'b11;
      key_sync <= 2'b11;
    end else begin
      key_meta <= key_raw;
      key_sync <= key_meta;
    end
  end

  // Bit 0 is ENTER, bit 1 is CLEAR; a level change is accepted only after
  // DEB_CYCLES consecutive differing samples, and only presses emit a pulse.
  for (genvar k = 0; k < 2; k++) begin : g_deb
    logic [DW-1:0] cnt;
    logic          level;
    logic          pulse;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt   <= '0;
        level <= 1'b1;
        pulse <= 1'b0;
      end else begin
        pulse <= 1'b0;
        if (key_sync[k] == level) begin
          cnt <= '0;
        end else if (cnt == DEB_LAST) begin
          cnt   <= '0;
          level <= key_sync[k];
          pulse <= ~key_sync[k];
        end else begin
          cnt <= cnt + DW'(1);
        end
      end
    end

    assign key_pulse[k] = pulse;
  end

  assign enter_p = key_pulse[0];
  assign clear_p = key_pulse[1];

  // Sign-extend to 6 bits so that negating -8 yields a true +8 before the range check.
  assign a_ext   = {{2{a_q[3]}}, a_q};
  assign b_ext   = {{2{b_q[3]}}, b_q};
  assign sum6    = sub_q ? (a_ext - b_ext) : (a_ext + b_ext);
  assign sum_ovf = (sum6 < -6'sd8) || (sum6 > 6'sd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ENTER_A;
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      ovf_q <= 1'b0;
      sub_q <= 1'b0;
    end else begin
      state <= state_d;
      a_q   <= a_d;
      b_q   <= b_d;
      r_q   <= r_d;
      ovf_q <= ovf_d;
      sub_q <= sub_d;
    end
  end

  // CLEAR is applied last so it overrides any ENTER seen in the same cycle.
  always_comb begin
    state_d = state;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    sub_d   = sub_q;

    case (state)
      ENTER_A: begin
        a_d = io.sw_val;
        if (enter_p) state_d = ENTER_B;
      end
      ENTER_B: begin
        b_d   = io.sw_val;
        sub_d = io.sub_sel;
        if (enter_p) state_d = EXEC;
      end
      EXEC: begin
        r_d     = sum6[3:0];
        ovf_d   = sum_ovf;
        state_d = SHOW;
      end
      SHOW: begin
        if (enter_p) state_d = ENTER_A;
      end
      default: state_d = ENTER_A;
    endcase

    if (clear_p) begin
      state_d = ENTER_A;
      a_d     = '0;
      b_d     = '0;
      r_d     = '0;
      ovf_d   = 1'b0;
      sub_d   = 1'b0;
    end
  end

  // Free-running blink timebase; the FSM never restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign io.a_val    = a_q;
  assign io.b_val    = b_q;
  assign io.r_val    = r_q;
  assign io.ovf      = ovf_q;
  assign io.state_o  = state;
  assign io.a_blank  = (state == ENTER_A) & blink_phase;
  assign io.b_blank  = (state == ENTER_B) & blink_phase;
  assign io.r_blank  = (state != SHOW);
  assign io.ovf_show = ovf_q & (state == SHOW) & ~blink_phase;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Directed plus randomized bench for operand_entry_ctrl, checked against a
// behavioural model of the operand/result rules and the blink timebase.
module tb_operand_entry_ctrl;

  localparam int DEB   = 4;
  localparam int BLINK = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   tb_cyc;

  logic [1:0] m_state;
  logic [3:0] m_a;
  logic [3:0] m_b;
  logic [3:0] m_r;
  logic       m_ovf;

  operand_entry_ctrl_if io ();

  operand_entry_ctrl #(
    .DEB_CYCLES(DEB),
    .BLINK_DIV (BLINK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release; the display blink phase is derived from it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= 0;
    else        tb_cyc <= tb_cyc + 1;
  end

  function automatic logic blink_phase();
    return ((tb_cyc / BLINK) % 2) == 1;
  endfunction

  function automatic int to_int(input logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  function automatic void ref_op(input logic [3:0] a, input logic [3:0] b, input logic sub,
                                 output logic [3:0] r, output logic ovf);
    int res;
    res = sub ? to_int(a) - to_int(b) : to_int(a) + to_int(b);
    ovf = (res < -8) || (res > 7);
    r   = 4'(res);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    logic ph;
    ph = blink_phase();
    checkOutput({tag, ".state"},    32'(io.state_o),  32'(m_state));
    checkOutput({tag, ".a"},        32'(io.a_val),    32'(m_a));
    checkOutput({tag, ".b"},        32'(io.b_val),    32'(m_b));
    checkOutput({tag, ".r"},        32'(io.r_val),    32'(m_r));
    checkOutput({tag, ".ovf"},      32'(io.ovf),      32'(m_ovf));
    checkOutput({tag, ".a_blank"},  32'(io.a_blank),  32'((m_state == 2'd0) & ph));
    checkOutput({tag, ".b_blank"},  32'(io.b_blank),  32'((m_state == 2'd1) & ph));
    checkOutput({tag, ".r_blank"},  32'(io.r_blank),  32'(m_state != 2'd3));
    checkOutput({tag, ".ovf_show"}, 32'(io.ovf_show), 32'(m_ovf & (m_state == 2'd3) & ~ph));
  endtask

  task automatic applyStimulus(input logic enter, input logic clear, input int low_cycles, input int high_cycles);
    io.key_enter_n = ~enter;
    io.key_clear_n = ~clear;
    repeat (low_cycles) @(negedge clk);
    io.key_enter_n = 1'b1;
    io.key_clear_n = 1'b1;
    repeat (high_cycles) @(negedge clk);
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic sub, input string tag);
    io.sw_val = a;
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 1'b0, DEB + 4, DEB + 4);
    m_state = 2'd1; m_a = a; m_b = a;
    checkAll({tag, ".in_b"});
    io.sw_val  = b;
    io.sub_sel = sub;
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 1'b0, DEB + 4, DEB + 4);
    m_state = 2'd3; m_b = b;
    ref_op(a, b, sub, m_r, m_ovf);
    checkAll({tag, ".show"});
  endtask

  task automatic back_to_a(input string tag);
    applyStimulus(1'b1, 1'b0, DEB + 4, DEB + 4);
    m_state = 2'd0; m_a = io.sw_val;
    checkAll(tag);
  endtask

  initial begin
    int first_exec, exec_cnt, first_show;
    logic [3:0] ra, rb;
    logic       rs;

    checks = 0;
    errors = 0;
    rst_n          = 1'b0;
    io.sw_val      = 4'd6;
    io.sub_sel     = 1'b0;
    io.key_enter_n = 1'b1;
    io.key_clear_n = 1'b1;
    m_state = 2'd0; m_a = '0; m_b = '0; m_r = '0; m_ovf = 1'b0;

    // Reset values, then release between clock edges and confirm blink starts low.
    repeat (3) @(negedge clk);
    checkAll("reset");
    #2 rst_n = 1'b1;
    repeat (BLINK - 1) @(negedge clk);
    m_a = 4'd6;
    checkAll("blink_low");
    checkOutput("blink_low.a_blank_raw", 32'(io.a_blank), 32'd0);
    @(negedge clk);
    checkOutput("blink_high.a_blank_raw", 32'(io.a_blank), 32'd1);

    // 3 + 2 with state trace and latency from the second press.
    io.sw_val = 4'd3;
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 1'b0, DEB + 4, DEB + 4);
    m_state = 2'd1; m_a = 4'd3; m_b = 4'd3;
    checkAll("add32.in_b");
    io.sw_val = 4'd2; io.sub_sel = 1'b0;
    repeat (2) @(negedge clk);
    first_exec = 0; exec_cnt = 0; first_show = 0;
    io.key_enter_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (io.state_o == 2'd2) begin
        exec_cnt++;
        if (first_exec == 0) first_exec = i;
      end
      if (!io.r_blank && first_show == 0) first_show = i;
    end
    io.key_enter_n = 1'b1;
    repeat (DEB + 4) @(negedge clk);
    m_state = 2'd3; m_b = 4'd2;
    ref_op(4'd3, 4'd2, 1'b0, m_r, m_ovf);
    checkAll("add32.show");
    checkOutput("add32.r_literal", 32'(io.r_val), 32'd5);
    checkOutput("add32.exec_first", first_exec, DEB + 3);
    checkOutput("add32.exec_len", exec_cnt, 1);
    checkOutput("add32.press_to_show", first_show - (DEB + 2), 2);
    back_to_a("add32.back");

    // 7 + 1 overflows; overflow indicator follows the blink in SHOW.
    run_op(4'd7, 4'd1, 1'b0, "add71");
    checkOutput("add71.r_literal", 32'(io.r_val), 32'd8);
    for (int i = 0; i < 3 * BLINK; i++) begin
      @(negedge clk);
      checkOutput("add71.ovf_show", 32'(io.ovf_show), 32'(m_ovf & ~blink_phase()));
    end
    back_to_a("add71.back");

    run_op(4'd0, 4'b1000, 1'b1, "sub0m8");
    back_to_a("sub0m8.back");
    run_op(4'b1000, 4'b1000, 1'b1, "subm8m8");
    checkOutput("subm8m8.r_literal", 32'(io.r_val), 32'd0);
    back_to_a("subm8m8.back");

    for (int n = 0; n < 12; n++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, "rand");
      back_to_a("rand.back");
    end

    // Bouncing ENTER then a long hold advances exactly once.
    io.sw_val = 4'd7;
    repeat (2) @(negedge clk);
    io.key_enter_n = 1'b0; @(negedge clk);
    io.key_enter_n = 1'b1; @(negedge clk);
    io.key_enter_n = 1'b0;
    repeat (DEB + 100) @(negedge clk);
    io.key_enter_n = 1'b1;
    repeat (DEB + 6) @(negedge clk);
    m_state = 2'd1; m_a = 4'd7; m_b = 4'd7;
    checkAll("bounce");
    applyStimulus(1'b1, 1'b0, DEB - 1, 1);
    applyStimulus(1'b1, 1'b0, DEB - 1, DEB + 6);
    checkAll("short_press");
    io.sw_val = 4'd1; io.sub_sel = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 1'b0, DEB + 4, DEB + 4);
    m_state = 2'd3; m_b = 4'd1;
    ref_op(4'd7, 4'd1, 1'b0, m_r, m_ovf);
    checkAll("pre_clear");

    // CLEAR and ENTER accepted together in SHOW: clear wins.
    io.sw_val = 4'd5;
    io.key_enter_n = 1'b0;
    io.key_clear_n = 1'b0;
    repeat (DEB + 2) @(negedge clk);
    checkOutput("clear.pulse_cycle_state", 32'(io.state_o), 32'd3);
    @(negedge clk);
    m_state = 2'd0; m_a = '0; m_b = '0; m_r = '0; m_ovf = 1'b0;
    checkAll("clear");
    @(negedge clk);
    m_a = 4'd5;
    checkAll("clear.track");
    io.key_enter_n = 1'b1;
    io.key_clear_n = 1'b1;
    repeat (DEB + 4) @(negedge clk);

    // Async reset while in EXEC.
    io.sw_val = 4'd6;
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 1'b0, DEB + 4, DEB + 4);
    io.sw_val = 4'd3; io.sub_sel = 1'b1;
    repeat (2) @(negedge clk);
    io.key_enter_n = 1'b0;
    repeat (DEB + 3) @(negedge clk);
    checkOutput("exec.state", 32'(io.state_o), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    m_state = 2'd0; m_a = '0; m_b = '0; m_r = '0; m_ovf = 1'b0;
    checkAll("exec_reset");
    io.key_enter_n = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    m_a = 4'd3;
    checkAll("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
